// File: rtl/config_sequencer.sv
// Front-panel configuration editor: loads a register set, lets the user step
// fields with UP/DOWN (with auto-repeat) and cursor LEFT/RIGHT, then commits it.
//
// state  | meaning
// IDLE   | run mode, nothing being edited
// LOAD   | one cycle: copy current register set into the edit fields
// EDIT   | buttons adjust cursor and fields
// COMMIT | wr_req held, fields frozen until wr_ack
module config_sequencer #(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cfg_mode,
  input  logic [3:0] btn_db,
  input  logic [6:0] cur_f0,
  input  logic [6:0] cur_f1,
  input  logic [6:0] cur_f2,
  output logic [1:0] edit_mode,
  output logic [1:0] cursor,
  output logic [6:0] f0,
  output logic [6:0] f1,
  output logic [6:0] f2,
  output logic       wr_req,
  output logic [1:0] wr_sel,
  input  logic       wr_ack
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, EDIT, COMMIT} state_t;

  function automatic logic [6:0] fmin(input logic [1:0] mode, input logic [1:0] idx);
    return (mode == 2'b10 && idx != 2'd2) ? 7'd1 : 7'd0;
  endfunction

  function automatic logic [6:0] fmax(input logic [1:0] mode, input logic [1:0] idx);
    if (mode == 2'b10) begin
      case (idx)
        2'd0:    return 7'd31;
        2'd1:    return 7'd12;
        default: return 7'd99;
      endcase
    end
    return (idx == 2'd0) ? 7'd23 : 7'd59;
  endfunction

  // Out-of-range loaded values snap to the minimum instead of stepping.
  function automatic logic [6:0] step_field(input logic [6:0] v, input logic [1:0] mode,
                                            input logic [1:0] idx, input logic up);
    logic [6:0] lo, hi;
    lo = fmin(mode, idx);
    hi = fmax(mode, idx);
    if (v < lo || v > hi) return lo;
    if (up) return (v == hi) ? lo : v + 7'd1;
    return (v == lo) ? hi : v - 7'd1;
  endfunction

  state_t        state;
  logic [3:0]    btn_r, btn_p, armed;
  logic [CW-1:0] rpt_cnt;
  logic          rpt_act;

  logic [3:0] rise;
  logic       one_held, rpt_tick, inc, dec, mv_r, mv_l;
  logic [6:0] fsel, fnext;

  // armed stays low for any button held through reset until it is released.
  always_comb begin
    rise     = btn_r & ~btn_p & armed;
    one_held = btn_r[0] ^ btn_r[1];
    rpt_tick = rpt_act && one_held && (rpt_cnt == '0);
    inc      = one_held && btn_r[0] && (rise[0] || rpt_tick);
    dec      = one_held && btn_r[1] && (rise[1] || rpt_tick);
    mv_r     = rise[3] && !btn_r[2];
    mv_l     = rise[2] && !btn_r[3];
    case (cursor)
      2'd1:    fsel = f1;
      2'd2:    fsel = f2;
      default: fsel = f0;
    endcase
    fnext = step_field(fsel, edit_mode, cursor, inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      edit_mode <= '0;
      cursor    <= '0;
      f0        <= '0;
      f1        <= '0;
      f2        <= '0;
      wr_req    <= 1'b0;
      wr_sel    <= '0;
      rpt_cnt   <= '0;
      rpt_act   <= 1'b0;
      btn_r     <= '0;
      btn_p     <= '0;
      armed     <= '0;
    end else begin
      btn_r   <= btn_db;
      btn_p   <= btn_r;
      armed   <= armed | ~btn_db;
      rpt_cnt <= '0;
      rpt_act <= 1'b0;
      case (state)
        IDLE: begin
          edit_mode <= '0;
          if (cfg_mode != 2'b00) state <= LOAD;
        end
        LOAD: begin
          f0        <= cur_f0;
          f1        <= cur_f1;
          f2        <= cur_f2;
          cursor    <= '0;
          edit_mode <= cfg_mode;
          state     <= (cfg_mode == 2'b00) ? IDLE : EDIT;
        end
        EDIT: begin
          if (cfg_mode != edit_mode) begin
            state  <= COMMIT;
            wr_req <= 1'b1;
            wr_sel <= edit_mode;
          end else begin
            if (inc || dec) begin
              case (cursor)
                2'd1:    f1 <= fnext;
                2'd2:    f2 <= fnext;
                default: f0 <= fnext;
              endcase
            end
            if (mv_r)      cursor <= (cursor == 2'd2) ? 2'd0 : cursor + 2'd1;
            else if (mv_l) cursor <= (cursor == 2'd0) ? 2'd2 : cursor - 2'd1;
            // Down-counter: first step HOLD_CYCLES after the press, then every REPEAT_CYCLES.
            if (one_held) begin
              if (rise[0] || rise[1]) begin
                rpt_act <= 1'b1;
                rpt_cnt <= CW'(HOLD_CYCLES - 1);
              end else if (rpt_act) begin
                rpt_act <= 1'b1;
                rpt_cnt <= (rpt_cnt == '0) ? CW'(REPEAT_CYCLES - 1) : rpt_cnt - CW'(1);
              end
            end
          end
        end
        COMMIT: begin
          if (wr_ack) begin
            wr_req <= 1'b0;
            if (cfg_mode == 2'b00) begin
              state     <= IDLE;
              edit_mode <= '0;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_sequencer.sv
// Scenario bench for config_sequencer: expected output vectors are queued when
// stimulus is applied and compared when the corresponding cycle is sampled.
module tb_config_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cfg_mode = 2'b00;
  logic [3:0] btn_db = 4'b0000;
  logic [6:0] cur_f0 = '0, cur_f1 = '0, cur_f2 = '0;
  logic       wr_ack = 1'b0;
  logic [1:0] edit_mode, cursor, wr_sel;
  logic [6:0] f0, f1, f2;
  logic       wr_req;

  localparam logic [3:0] UP = 4'b0001, DN = 4'b0010, LT = 4'b0100, RT = 4'b1000;

  int vectors = 0;
  int miscompares = 0;
  logic [27:0] exp_q[$];
  logic [27:0] obs;

  config_sequencer #(.HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .btn_db(btn_db),
    .cur_f0(cur_f0), .cur_f1(cur_f1), .cur_f2(cur_f2),
    .edit_mode(edit_mode), .cursor(cursor), .f0(f0), .f1(f1), .f2(f2),
    .wr_req(wr_req), .wr_sel(wr_sel), .wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  assign obs = {edit_mode, cursor, f0, f1, f2, wr_req, wr_sel};

  // Packs an expected output vector in the same layout as obs.
  function automatic logic [27:0] ov(input logic [1:0] em, input logic [1:0] cu,
                                     input logic [6:0] a, input logic [6:0] b,
                                     input logic [6:0] c, input logic req,
                                     input logic [1:0] sel);
    return {em, cu, a, b, c, req, sel};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] b);
    btn_db = b;
    cyc(2);
  endtask

  task automatic release_btn();
    btn_db = 4'b0000;
    cyc(1);
  endtask

  task automatic test_reset();
    logic [27:0] e;
    cyc(2);
    exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_state got=%h want=%h", obs, e); end
    // UP held across reset release must not act once EDIT is reached.
    btn_db = UP; cfg_mode = 2'b01; cur_f0 = 5; cur_f1 = 6; cur_f2 = 7;
    cyc(1);
    reset = 1'b0;
    exp_q.push_back(ov(1, 0, 5, 6, 7, 0, 0));
    cyc(4);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL held_thru_reset got=%h want=%h", obs, e); end
    release_btn();
    exp_q.push_back(ov(1, 0, 6, 6, 7, 0, 0));
    press(UP);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL repress_after_reset got=%h want=%h", obs, e); end
    release_btn();
    cfg_mode = 2'b00;
    exp_q.push_back(ov(1, 0, 6, 6, 7, 1, 1));
    cyc(1);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL commit_enter got=%h want=%h", obs, e); end
    wr_ack = 1'b1;
    exp_q.push_back(ov(0, 0, 6, 6, 7, 0, 1));
    cyc(1);
    wr_ack = 1'b0;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL commit_to_idle got=%h want=%h", obs, e); end
  endtask

  task automatic test_wrap();
    logic [27:0] e;
    cur_f0 = 23; cur_f1 = 59; cur_f2 = 58; cfg_mode = 2'b01;
    exp_q.push_back(ov(0, 0, 6, 6, 7, 0, 1));
    exp_q.push_back(ov(1, 0, 23, 59, 58, 0, 1));
    cyc(1);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL load_cycle got=%h want=%h", obs, e); end
    cyc(1);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL load_done got=%h want=%h", obs, e); end
    exp_q.push_back(ov(1, 0, 0, 59, 58, 0, 1));
    press(UP);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL hour_up_wrap got=%h want=%h", obs, e); end
    release_btn();
    exp_q.push_back(ov(1, 0, 23, 59, 58, 0, 1));
    press(DN);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL hour_down_wrap got=%h want=%h", obs, e); end
    release_btn();
  endtask

  task automatic test_mode_switch();
    logic [27:0] e;
    cur_f0 = 1; cur_f1 = 12; cur_f2 = 0; cfg_mode = 2'b10;
    exp_q.push_back(ov(1, 0, 23, 59, 58, 1, 1));
    cyc(1);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL switch_commit got=%h want=%h", obs, e); end
    wr_ack = 1'b1;
    exp_q.push_back(ov(1, 0, 23, 59, 58, 0, 1));
    cyc(1);
    wr_ack = 1'b0;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL switch_load got=%h want=%h", obs, e); end
    exp_q.push_back(ov(2, 0, 1, 12, 0, 0, 1));
    cyc(1);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL switch_date_edit got=%h want=%h", obs, e); end
  endtask

  task automatic test_cursor_date();
    logic [27:0] e;
    exp_q.push_back(ov(2, 2, 1, 12, 0, 0, 1));
    exp_q.push_back(ov(2, 2, 1, 12, 99, 0, 1));
    exp_q.push_back(ov(2, 0, 1, 12, 99, 0, 1));
    exp_q.push_back(ov(2, 0, 31, 12, 99, 0, 1));
    exp_q.push_back(ov(2, 0, 1, 12, 99, 0, 1));
    press(LT);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL left_wrap got=%h want=%h", obs, e); end
    release_btn();
    press(DN);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL year_down_wrap got=%h want=%h", obs, e); end
    release_btn();
    press(RT);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL right_wrap got=%h want=%h", obs, e); end
    release_btn();
    press(DN);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL day_down_wrap got=%h want=%h", obs, e); end
    release_btn();
    press(UP);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL day_up_wrap got=%h want=%h", obs, e); end
    release_btn();
  endtask

  task automatic test_autorepeat();
    logic [27:0] e;
    int v;
    cur_f0 = 3; cur_f1 = 10; cur_f2 = 4; cfg_mode = 2'b01;
    cyc(1);
    wr_ack = 1'b1;
    cyc(1);
    wr_ack = 1'b0;
    cyc(1);
    exp_q.push_back(ov(1, 1, 3, 10, 4, 0, 2));
    press(RT);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL repeat_setup got=%h want=%h", obs, e); end
    release_btn();
    exp_q.push_back(ov(1, 1, 3, 11, 4, 0, 2));
    press(UP);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL repeat_press got=%h want=%h", obs, e); end
    for (int k = 1; k <= 20; k++) begin
      v = 11;
      if (k >= 8) v++;
      for (int s = 12; s <= k; s += 4) v++;
      exp_q.push_back(ov(1, 1, 3, 7'(v), 4, 0, 2));
      cyc(1);
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL repeat_step_%0d got=%h want=%h", k, obs, e); end
    end
    btn_db = 4'b0000;
    exp_q.push_back(ov(1, 1, 3, 15, 4, 0, 2));
    cyc(8);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL repeat_release got=%h want=%h", obs, e); end
  endtask

  task automatic test_both();
    logic [27:0] e;
    exp_q.push_back(ov(1, 1, 3, 15, 4, 0, 2));
    btn_db = UP | DN | LT | RT;
    cyc(14);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL all_buttons_noop got=%h want=%h", obs, e); end
    release_btn();
    exp_q.push_back(ov(1, 2, 3, 16, 4, 0, 2));
    press(UP | RT);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL value_and_cursor got=%h want=%h", obs, e); end
    release_btn();
    wr_ack = 1'b1;
    exp_q.push_back(ov(1, 2, 3, 16, 4, 0, 2));
    cyc(2);
    wr_ack = 1'b0;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL stray_ack got=%h want=%h", obs, e); end
  endtask

  task automatic test_commit_delay();
    logic [27:0] e;
    cfg_mode = 2'b00;
    for (int k = 0; k < 5; k++) exp_q.push_back(ov(1, 2, 3, 16, 4, 1, 1));
    cyc(1);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL delay_commit_0 got=%h want=%h", obs, e); end
    cfg_mode = 2'b10;
    btn_db = UP;
    for (int k = 1; k < 5; k++) begin
      cyc(1);
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("FAIL delay_commit_%0d got=%h want=%h", k, obs, e); end
    end
    cfg_mode = 2'b00;
    btn_db = 4'b0000;
    wr_ack = 1'b1;
    exp_q.push_back(ov(0, 2, 3, 16, 4, 0, 1));
    exp_q.push_back(ov(0, 2, 3, 16, 4, 0, 1));
    cyc(1);
    wr_ack = 1'b0;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL delay_ack_idle got=%h want=%h", obs, e); end
    cyc(3);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL idle_stays got=%h want=%h", obs, e); end
  endtask

  task automatic test_clamp();
    logic [27:0] e;
    cur_f0 = 0; cur_f1 = 13; cur_f2 = 120; cfg_mode = 2'b10;
    exp_q.push_back(ov(2, 0, 0, 13, 120, 0, 1));
    exp_q.push_back(ov(2, 0, 1, 13, 120, 0, 1));
    exp_q.push_back(ov(2, 1, 1, 1, 120, 0, 1));
    exp_q.push_back(ov(2, 2, 1, 1, 0, 0, 1));
    cyc(2);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL clamp_load got=%h want=%h", obs, e); end
    press(UP);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL clamp_day_up got=%h want=%h", obs, e); end
    release_btn();
    press(RT); release_btn();
    press(DN);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL clamp_month_down got=%h want=%h", obs, e); end
    release_btn();
    press(RT); release_btn();
    press(UP);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL clamp_year_up got=%h want=%h", obs, e); end
    release_btn();
  endtask

  task automatic test_reset_commit();
    logic [27:0] e;
    cfg_mode = 2'b00;
    exp_q.push_back(ov(2, 2, 1, 1, 0, 1, 2));
    exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(ov(0, 0, 0, 0, 0, 0, 0));
    cyc(1);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL pre_reset_commit got=%h want=%h", obs, e); end
    reset = 1'b1;
    cyc(1);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL reset_in_commit got=%h want=%h", obs, e); end
    reset = 1'b0;
    cyc(4);
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("FAIL no_commit_retry got=%h want=%h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_mode_switch();
    test_cursor_date();
    test_autorepeat();
    test_both();
    test_commit_delay();
    test_clamp();
    test_reset_commit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/config_sequencer.md
CONFIG_SEQUENCER -- requirements
Module: config_sequencer

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 50_000_000: cycles UP/DOWN must be held before auto-repeat starts.
REQ-002 SHALL provide parameter REPEAT_CYCLES, default 10_000_000: cycles between auto-repeat steps.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports:
  clk  in  1  system clock
  reset  in  1  synchronous active-high reset
  cfg_mode  in  2  debounced switches; 00 run, 01 edit time, 10 edit date, 11 edit timer
  btn_db  in  4  debounced buttons; [0] UP, [1] DOWN, [2] LEFT, [3] RIGHT
  cur_f0, cur_f1, cur_f2  in  7 each  current values of the selected register set
  edit_mode  out  2  mode currently being edited; 00 when idle
  cursor  out  2  selected field, 0..2
  f0, f1, f2  out  7 each  edit values
  wr_req  out  1  commit request
  wr_sel  out  2  target of commit; equals committed mode
  wr_ack  in  1  one-cycle commit acknowledge

Function
REQ-005 States SHALL be IDLE, LOAD, EDIT and COMMIT.
REQ-006 IDLE: cfg_mode != 00 SHALL go to LOAD next cycle.
REQ-007 LOAD: lasts one cycle; SHALL copy cur_f0..2 to f0..2, latch cfg_mode into edit_mode, set cursor=0, then go to EDIT.
REQ-008 EDIT: cfg_mode != edit_mode SHALL go to COMMIT with wr_sel=edit_mode.
REQ-009 COMMIT: wr_req SHALL be 1 and f0..2 and wr_sel SHALL be frozen until the cycle wr_ack=1 is sampled.
REQ-010 On wr_ack in COMMIT, the next state SHALL be IDLE when cfg_mode=00, otherwise LOAD. cfg_mode changes during COMMIT SHALL be ignored.
REQ-011 wr_ack outside COMMIT SHALL be ignored.
REQ-012 After leaving COMMIT, edit_mode SHALL read 00 in IDLE.
REQ-013 Button actions SHALL occur only in EDIT, and only on a 0->1 transition of the registered button (one action per press).
REQ-014 RIGHT SHALL set cursor = cursor+1, wrapping 2->0. LEFT SHALL set cursor = cursor-1, wrapping 0->2.
REQ-015 UP SHALL increment the field at cursor and DOWN SHALL decrement it, wrapping within that field's range.
REQ-016 Field ranges:
  time: f0 0..23, f1 0..59, f2 0..59
  date: f0 1..31, f1 1..12, f2 0..99
  timer: same as time
REQ-017 Wrap examples: UP at max -> min; DOWN at min -> max (date day 1 DOWN -> 31).
REQ-018 No day-of-month validity check is performed.
REQ-019 A loaded value outside its range SHALL be clamped to the range minimum on the first UP/DOWN.
REQ-020 UP and DOWN both high SHALL cause no value change, and the auto-repeat counter SHALL clear. LEFT and RIGHT both high SHALL cause no cursor change.
REQ-021 Value and cursor actions in the same cycle SHALL both apply, with the value change using the pre-move cursor.
REQ-022 Auto-repeat: while exactly one of UP/DOWN stays high after its press action, a counter SHALL run.
REQ-023 The first repeat step SHALL occur HOLD_CYCLES cycles after the press action, then one step every REPEAT_CYCLES cycles. Release SHALL clear the counter. LEFT/RIGHT SHALL never repeat.
REQ-024 Counter width SHALL be sized by $clog2 of the larger parameter.

Reset
REQ-025 Reset SHALL force, on the next clock edge: state IDLE, edit_mode=00, cursor=0, f0=f1=f2=0, wr_req=0, wr_sel=00, auto-repeat counter=0, button history=0.
REQ-026 Reset asserted during COMMIT SHALL drop wr_req with no commit retry.
REQ-027 A button already held when reset is released SHALL NOT generate an action until it is released and pressed again.

Verification (HOLD_CYCLES=8, REPEAT_CYCLES=4)
REQ-028 Test: cfg_mode 00->01 with cur=(23,59,58), then UP.
  Required: LOAD one cycle; f0 becomes 0 (wrap); cursor=0.
REQ-029 Test: in date mode, cursor=0, f0=1; press LEFT, then DOWN.
  Required: cursor=2; f2 decrements, e.g. 0->99.
REQ-030 Test: hold UP for 20 cycles in time mode, cursor=1, f1=10.
  Required: f1=11 at press, 12 at +8, 13 at +12, 14 at +16, 15 at +20.
REQ-031 Test: cfg_mode 01->00; wr_ack delayed 5 cycles.
  Required: wr_req high for 5 cycles; wr_sel=01; f0..2 stable; IDLE after ack.
REQ-032 Test: cfg_mode 01->10 directly.
  Required: COMMIT with wr_sel=01, then LOAD of the date set after wr_ack.
REQ-033 Test: assert reset during COMMIT; also UP+DOWN held together in EDIT.
  Required: on reset, all outputs take reset values next cycle. With UP+DOWN, fields do not change.
